// File: rtl/mem_port_pkg.sv
// Shared types and constants for the core-side fetch/memory port driver.
package mem_port_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RESTART = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RUN     = 2'd3
  } mp_state_e;

  localparam int LOAD_LAT = 2;

endpackage

// File: rtl/load_tracker.sv
// Checks that load data returns exactly LOAD_LAT cycles after the load pulse
// and registers the returned data towards the core.
module load_tracker
  import mem_port_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_load,
  input  logic               load_data_valid_i,
  input  logic [D_WIDTH-1:0] load_data_i,
  output logic               resp_valid_o,
  output logic [D_WIDTH-1:0] resp_data_o,
  output logic               protocol_err_o
);

  logic [LOAD_LAT-1:0] exp_q;

  // Bit LOAD_LAT-1 holds the load issued LOAD_LAT cycles ago; any disagreement
  // with the strobe (early, late or spurious data) latches the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q          <= '0;
      resp_valid_o   <= 1'b0;
      resp_data_o    <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      exp_q          <= {exp_q[LOAD_LAT-2:0], issue_load};
      resp_valid_o   <= load_data_valid_i;
      if (load_data_valid_i) resp_data_o <= load_data_i;
      protocol_err_o <= protocol_err_o | (load_data_valid_i != exp_q[LOAD_LAT-1]);
    end
  end

endmodule

// File: rtl/mem_port_driver.sv
// Core-side initiator: turns load/store requests and redirects into restart and
// load/store pulses, squashes stale fetches and checks load return latency.
//
// state   | meaning
// BOOT    | first cycle out of reset, schedules restart at RESET_PC
// RESTART | restart_o pulse with addr_o = target
// DRAIN   | squash instructions fetched before the restart took effect
// RUN     | normal operation, requests accepted
module mem_port_driver
  import mem_port_pkg::*;
#(
  parameter int                 A_WIDTH  = 10,
  parameter int                 I_WIDTH  = 17,
  parameter int                 D_WIDTH  = 32,
  parameter int                 DRAIN    = 2,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_store_i,
  input  logic [A_WIDTH-1:0] req_addr_i,
  input  logic [D_WIDTH-1:0] req_data_i,
  input  logic               redirect_valid_i,
  input  logic [A_WIDTH-1:0] redirect_pc_i,
  output logic               resp_valid_o,
  output logic [D_WIDTH-1:0] resp_data_o,
  output logic               restart_o,
  output logic               load_store_valid_o,
  output logic               store_en_o,
  output logic [A_WIDTH-1:0] addr_o,
  output logic [D_WIDTH-1:0] store_data_o,
  input  logic               load_data_valid_i,
  input  logic [D_WIDTH-1:0] load_data_i,
  input  logic               instr_valid_i,
  input  logic [I_WIDTH-1:0] instr_i,
  output logic               instr_valid_o,
  output logic [I_WIDTH-1:0] instr_o,
  output logic               protocol_err_o
);

  localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

  mp_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  logic [A_WIDTH-1:0] target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    target  = (state_q == ST_BOOT) ? RESET_PC : redirect_pc_i;
    case (state_q)
      ST_BOOT: state_d = ST_RESTART;
      ST_RESTART: begin
        if (redirect_valid_i) begin
          state_d = ST_RESTART;
        end else begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LAST;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid_i)  state_d = ST_RESTART;
        else if (cnt_q == '0)  state_d = ST_RUN;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (redirect_valid_i) state_d = ST_RESTART;
        else                  accept  = req_valid_i;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign req_ready_o   = (state_q == ST_RUN) & ~redirect_valid_i;
  assign instr_valid_o = instr_valid_i & (state_q == ST_RUN);
  assign instr_o       = instr_i;

  // Pulses are registered off the next state so restart_o lines up with RESTART.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restart_o          <= 1'b0;
      load_store_valid_o <= 1'b0;
      store_en_o         <= 1'b0;
      addr_o             <= '0;
      store_data_o       <= '0;
    end else begin
      restart_o          <= (state_d == ST_RESTART);
      load_store_valid_o <= accept;
      store_en_o         <= accept & req_store_i;
      if (state_d == ST_RESTART) addr_o <= target;
      else if (accept)           addr_o <= req_addr_i;
      if (accept) store_data_o <= req_data_i;
    end
  end

  load_tracker #(.D_WIDTH(D_WIDTH)) u_load_tracker (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_load       (load_store_valid_o & ~store_en_o),
    .load_data_valid_i(load_data_valid_i),
    .load_data_i      (load_data_i),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .protocol_err_o   (protocol_err_o)
  );

endmodule

// File: tb/tb_mem_port_driver.sv
// Bench for mem_port_driver: vector table for the request/redirect flow, a
// scoreboard for restart, load/store and response events, and hand sequences.
module tb_mem_port_driver;
  localparam int AW = 10;
  localparam int IW = 17;
  localparam int DW = 32;
  localparam int DR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_store;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          restart, lsv, store_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] store_data;
  logic          ldv;
  logic [DW-1:0] ldata;
  logic          instr_valid_in, instr_valid_out;
  logic [IW-1:0] instr_in, instr_out;
  logic          perr;

  mem_port_driver #(
    .A_WIDTH(AW), .I_WIDTH(IW), .D_WIDTH(DW), .DRAIN(DR), .RESET_PC(10'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .restart_o(restart), .load_store_valid_o(lsv), .store_en_o(store_en),
    .addr_o(addr), .store_data_o(store_data),
    .load_data_valid_i(ldv), .load_data_i(ldata),
    .instr_valid_i(instr_valid_in), .instr_i(instr_in),
    .instr_valid_o(instr_valid_out), .instr_o(instr_out),
    .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic st; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
  typedef struct { int c; logic [DW-1:0] d; } resp_t;
  typedef struct { int c; logic [AW-1:0] a; } rst_t;
  txn_t  txn_q[$];
  resp_t resp_q[$];
  rst_t  restart_q[$];

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 10'h03A) ? 32'hDEADBEEF : {16'hC0DE, 6'h00, a};
  endfunction

  // Memory model: returns load data two cycles after the load pulse, or one
  // cycle after it when early is set.
  logic          p0 = 1'b0, p1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  bit            early = 1'b0;

  task automatic tick();
    logic          iss;
    logic [DW-1:0] dnow;
    @(posedge clk); #1;
    iss  = lsv & ~store_en;
    dnow = mem_fn(addr);
    if (early) begin ldv = p0; ldata = d0; end
    else       begin ldv = p1; ldata = d1; end
    p1 = p0; d1 = d0; p0 = iss; d0 = dnow;
  endtask

  task automatic drive(input logic v, input logic st, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rv, input logic [AW-1:0] rpc,
                       input logic iv, input logic rdy);
    req_valid = v; req_store = st; req_addr = a; req_data = d;
    redirect_valid = rv; redirect_pc = rpc;
    instr_valid_in = iv; instr_in = IW'($urandom);
    if (v && rdy) begin
      txn_q.push_back('{cyc + 1, st, a, d});
      if (!st) resp_q.push_back('{cyc + (early ? 3 : 4), mem_fn(a)});
    end
    if (rv) restart_q.push_back('{cyc + 1, rpc});
  endtask

  task automatic check_comb(input logic rdy, input logic ivo);
    @(negedge clk);
    chk("req_ready", req_ready, rdy);
    chk("instr_valid_o", instr_valid_out, ivo);
    chk("instr_o", instr_out, instr_in);
  endtask

  task automatic idle();
    tick();
    drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 10'h000, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    txn_t  t;
    resp_t r;
    rst_t  s;
    if (rst_n) begin
      chk("restart_with_lsv", restart & lsv, 1'b0);
      if (store_en && !lsv) chk("store_en_alone", store_en, 1'b0);
      if (restart) begin
        if (restart_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL restart_unexpected: got restart addr %0h expected none (cycle %0d)", addr, cyc);
        end else begin
          s = restart_q.pop_front();
          chk("restart_cycle", cyc, s.c);
          chk("restart_addr", addr, s.a);
        end
      end
      if (lsv) begin
        if (txn_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL lsv_unexpected: got addr %0h expected none (cycle %0d)", addr, cyc);
        end else begin
          t = txn_q.pop_front();
          chk("lsv_cycle", cyc, t.c);
          chk("store_en", store_en, t.st);
          chk("ls_addr", addr, t.a);
          if (t.st) chk("store_data", store_data, t.d);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected: got data %0h expected none (cycle %0d)", resp_data, cyc);
        end else begin
          r = resp_q.pop_front();
          chk("resp_cycle", cyc, r.c);
          chk("resp_data", resp_data, r.d);
        end
      end
    end
  end

  typedef struct {
    logic v; logic st; logic [AW-1:0] a; logic [DW-1:0] d;
    logic rv; logic [AW-1:0] rpc; logic iv; logic rdy; logic ivo;
  } vec_t;
  vec_t vt[18];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    for (int i = 0; i < 18; i++)
      vt[i] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
    vt[0]  = '{1'b1, 1'b0, 10'h03A, 32'h0,        1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 10'h010, 32'hA5A50001, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 10'h011, 32'h0,        1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 10'h012, 32'h0,        1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 10'h077, 32'h0,        1'b1, 10'h155, 1'b1, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 10'h078, 32'h0,        1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 10'h079, 32'h0,        1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 1'b0, 1'b0};

    req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ldv = 1'b0; ldata = '0;
    instr_valid_in = 1'b1; instr_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_restart", restart, 1'b0);
    chk("rst_lsv", lsv, 1'b0);
    chk("rst_store_en", store_en, 1'b0);
    chk("rst_addr", addr, 10'h000);
    chk("rst_store_data", store_data, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_instr_valid", instr_valid_out, 1'b0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    r0 = cyc;
    restart_q.push_back('{r0 + 1, 10'h000});
    @(negedge clk);
    chk("boot_restart", restart, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check_comb(k == 4, k == 4);
      chk("boot_restart_pulse", restart, k == 1);
      if (k == 1) chk("boot_restart_addr", addr, 10'h000);
    end

    for (int i = 0; i < 18; i++) begin
      tick();
      drive(vt[i].v, vt[i].st, vt[i].a, vt[i].d, vt[i].rv, vt[i].rpc, vt[i].iv, vt[i].rdy);
      check_comb(vt[i].rdy, vt[i].ivo);
    end

    // Redirect in DRAIN, then again in RESTART: back-to-back restarts.
    tick(); drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h100, 1'b1, 1'b0); check_comb(1'b0, 1'b1);
    idle(); check_comb(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h020, 1'b1, 1'b0); check_comb(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h040, 1'b1, 1'b0); check_comb(1'b0, 1'b0);
    chk("seqA_restart1", restart, 1'b1);
    chk("seqA_addr1", addr, 10'h020);
    idle(); check_comb(1'b0, 1'b0);
    chk("seqA_restart2", restart, 1'b1);
    chk("seqA_addr2", addr, 10'h040);
    idle(); check_comb(1'b0, 1'b0);
    chk("seqA_restart_end", restart, 1'b0);
    idle(); check_comb(1'b0, 1'b0);
    idle(); check_comb(1'b1, 1'b1);

    chk("perr_before_early", perr, 1'b0);

    // Early load return must latch the sticky error.
    early = 1'b1;
    tick(); drive(1'b1, 1'b0, 10'h0C5, 32'h0, 1'b0, 10'h000, 1'b1, 1'b1); check_comb(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      idle();
      @(negedge clk);
      chk("perr_sticky", perr, k >= 3);
    end

    chk("txn_q_empty", txn_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("restart_q_empty", restart_q.size(), 0);

    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("perr_cleared", perr, 1'b0);
    chk("resp_valid_cleared", resp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
